serial_adder: RTL and testbench

- Bit-serial unsigned adder. Consumes one operand pair per transaction and produces its WIDTH-bit sum and carry-out.
- Feeds one one-bit full-adder cell LSB-first, one bit per clock, and registers the cell's sum and carry results.
- Sits in the datapath as the area-minimal alternative to the parallel ripple mantissa adder. It is used where latency is not critical.
- Upstream and downstream connect through valid/ready handshakes.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_fa.sv | 14 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// State encoding and counter sizing live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell.
// Pure combinational sum and carry.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock.
// Valid/ready on both sides; outputs come from registers or state only.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_c;

  fullAdder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (fa_s),
    .cout(fa_c)
  );

  // New bit enters at the MSB; also valid for WIDTH == 1
  assign sum_nx = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (count == LAST) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready  = 1'b1;
      (state == RUN):  ;
      (state == DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_nx;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          count  <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vectors, corner sequences,
// and a randomized run scored against plain arithmetic.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       iv, ir, ov, ordy, cin, co;
  logic [7:0] a, b, s;
  logic       iv1, ir1, ov1, ordy1, cin1, co1;
  logic [0:0] a1, b1, s1;

  int n_cmp;
  int n_bad;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .a(a), .b(b), .cin(cin),
    .out_valid(ov), .out_ready(ordy),
    .sum(s), .cout(co)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(ordy1),
    .sum(s1), .cout(co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tv[4];
  logic [8:0] q[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] xa, input logic [7:0] xb,
                      input logic xc, output logic [7:0] rs,
                      output logic rc, output int lat);
    iv = 1'b1; a = xa; b = xb; cin = xc;
    @(posedge clk); #1;
    iv = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!ov && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s; rc = co;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  logic [7:0] rs;
  logic       rc;
  int         lat;
  int         got;
  int         sent;
  int         g;
  int         wd;
  int         cyc;
  logic       r;
  logic       acc;
  logic       bad;
  logic [8:0] ex;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    iv = 0; a = 0; b = 0; cin = 0; ordy = 0;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; ordy1 = 0;
    tv[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv[3] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};

    repeat (3) @(posedge clk);
    #3;
    check("rst in_ready", 32'(ir), 32'd1);
    check("rst out_valid", 32'(ov), 32'd0);
    check("rst sum/cout", 32'({co, s}), 32'd0);
    check("rst w1 outs", 32'({ir1, ov1, co1, s1}), 32'b1000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WIDTH=1: all eight input combinations
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("w1 lat %0d", i), 32'(lat), 32'd1);
      check($sformatf("w1 sum %0d", i), 32'({co1, s1}),
            32'((i >> 2) % 2 + (i >> 1) % 2 + i % 2));
      ordy1 = 1'b1;
      @(posedge clk); #1;
      ordy1 = 1'b0;
    end

    // Directed table
    foreach (tv[i]) begin
      run8(tv[i].a, tv[i].b, tv[i].cin, rs, rc, lat);
      check($sformatf("vec%0d lat", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d sum", i), 32'({rc, rs}),
            32'({tv[i].co, tv[i].s}));
    end

    // Backpressure: result held while new operands wait
    iv = 1'b1; a = 8'h30; b = 8'h0C; cin = 1'b0;
    @(posedge clk); #1;
    iv = 1'b0;
    lat = 0;
    while (!ov && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp lat", 32'(lat), 32'd8);
    iv = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold %0d", k), 32'({ov, ir, co, s}),
            32'({1'b1, 1'b0, 1'b0, 8'h3C}));
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("bp idle", 32'({ir, ov}), 32'b10);
    lat = 0;
    while (!ov && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) iv = 1'b0;
    end
    check("bp next lat", 32'(lat), 32'd9);
    check("bp next sum", 32'({co, s}), 32'h033);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;

    // Async reset mid-RUN
    iv = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst outs", 32'({ir, ov, co, s}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(posedge clk); #3;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ov || !ir) bad = 1'b1;
    end
    check("no valid after rst", 32'(bad), 32'd0);
    run8(8'h12, 8'h34, 1'b0, rs, rc, lat);
    check("post rst lat", 32'(lat), 32'd8);
    check("post rst sum", 32'({rc, rs}), 32'h046);

    // Randomized run with scoreboard
    got = 0; sent = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          g = $urandom_range(0, 3);
          repeat (g) begin
            @(posedge clk); #1;
          end
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
          iv = 1'b1;
          acc = 1'b0; wd = 0;
          while (!acc && wd < 100) begin
            @(negedge clk);
            r = ir;
            @(posedge clk); #1;
            wd++;
            acc = r;
          end
          if (!acc) begin
            check("rnd accept timeout", 32'(acc), 32'd1);
          end else begin
            q.push_back(9'(a) + 9'(b) + 9'(cin));
            sent++;
          end
          iv = 1'b0;
        end
      end
      begin
        cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          @(posedge clk); #1;
          ordy = 1'($urandom);
          @(negedge clk);
          if (ov && ordy) begin
            got++;
            if (q.size() == 0) begin
              check("rnd extra result", 32'(got), 32'(sent));
            end else begin
              ex = q.pop_front();
              check("rnd sum", 32'({co, s}), 32'(ex));
            end
          end
          cyc++;
        end
        @(posedge clk); #1;
        ordy = 1'b0;
      end
    join
    check("rnd sent", 32'(sent), 32'd1000);
    check("rnd received", 32'(got), 32'(sent));
    check("rnd queue empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
